// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the instruction-fetch block.
// No logic; constants only.
package instr_fetch_pkg;

    localparam int PC_W_DEFAULT = 12;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Control/status bundle between the sequencer and the fetch unit.
// Pure wiring; the slave modport is the fetch unit's view.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int D = PC_W_DEFAULT
);
    logic             Start;
    logic             Stall;
    logic             BranchEn;
    logic             Taken;
    logic [D-1:0]     Target;
    logic             HaltReq;
    logic [D-1:0]     PC;
    logic             FetchValid;
    logic             Done;
    logic [CNT_W-1:0] InstrCnt;

    modport master (
        output Start, Stall, BranchEn, Taken, Target, HaltReq,
        input  PC, FetchValid, Done, InstrCnt
    );

    modport slave (
        input  Start, Stall, BranchEn, Taken, Target, HaltReq,
        output PC, FetchValid, Done, InstrCnt
    );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection while running: halt > stall > taken branch > PC+1.
// Combinational, zero latency; adv_o marks a real PC advance. Macro: BRANCH_REL_EN.
module pc_next
    import instr_fetch_pkg::*;
#(
    parameter int D = PC_W_DEFAULT
) (
    input  logic [D-1:0] pc_i,
    input  logic         halt_i,
    input  logic         stall_i,
    input  logic         br_en_i,
    input  logic         taken_i,
    input  logic [D-1:0] target_i,
    output logic [D-1:0] pc_nxt_o,
    output logic         adv_o
);
    localparam logic [D-1:0] PC_ONE = D'(1);

    always_comb begin
        pc_nxt_o = pc_i;
        adv_o    = 1'b0;
        if (halt_i || stall_i) begin
            pc_nxt_o = pc_i;
        end else if (br_en_i && taken_i) begin
`ifdef BRANCH_REL_EN
            // Target is two's complement; D-bit add gives the modulo wrap for free
            pc_nxt_o = pc_i + target_i;
`else
            pc_nxt_o = target_i;
`endif
            adv_o    = 1'b1;
        end else begin
            pc_nxt_o = pc_i + PC_ONE;
            adv_o    = 1'b1;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Program counter sequencer with IDLE/RUN/HALT control and saturating advance count.
// All outputs registered, one cycle from inputs; Stall holds the PC. Macro: BRANCH_REL_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int           D          = PC_W_DEFAULT,
    parameter logic [D-1:0] START_ADDR = '0
) (
    input  logic        Clk,
    input  logic        Reset,
    instr_fetch_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D-1:0]     pc_nxt;
    logic             pc_adv;

    pc_next #(.D(D)) u_pc_next (
        .pc_i     (pc_q),
        .halt_i   (bus.HaltReq),
        .stall_i  (bus.Stall),
        .br_en_i  (bus.BranchEn),
        .taken_i  (bus.Taken),
        .target_i (bus.Target),
        .pc_nxt_o (pc_nxt),
        .adv_o    (pc_adv)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start)   state_d = RUN;
            RUN:     if (bus.HaltReq) state_d = HALT;
            HALT:    if (bus.Start)   state_d = RUN;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            RUN: begin
                pc_d = pc_nxt;
                if (pc_adv && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
            end
            // Restart from HALT rewinds; Start in IDLE keeps the reset PC
            HALT: if (bus.Start) begin
                pc_d  = START_ADDR;
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.PC         = pc_q;
    assign bus.InstrCnt   = cnt_q;
    assign bus.FetchValid = (state_q == RUN);
    assign bus.Done       = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, corner sequences, random vs model.
// Build with or without BRANCH_REL_EN; expectations follow the build.
module tb_instr_fetch;
    localparam int D      = 12;
    localparam int MOD    = 1 << D;
    localparam int CNTSAT = 65535;

`ifdef BRANCH_REL_EN
    localparam int BR_4_2   = 6;
    localparam int BR_4_FFB = 4095;
    localparam int AFTER    = 0;
`else
    localparam int BR_4_2   = 2;
    localparam int BR_4_FFB = 4091;
    localparam int AFTER    = 4092;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.D(D)) bus ();

    instr_fetch #(.D(D), .START_ADDR(12'h000)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit r, st, sl, be, tk, hr;
        int tg;
        int pc;
        bit fv, dn;
        int cnt;
    } vec_t;
    vec_t tv[$];

    // Model: run-state coded with its own constants, PC as a plain integer
    localparam int M_IDLE = 10, M_RUN = 11, M_HALT = 12;
    int m_st, m_pc, m_cnt;

    function automatic vec_t mk(bit r, bit st, bit sl, bit be, bit tk, bit hr, int tg,
                                int pc, bit fv, bit dn, int cnt);
        vec_t v;
        v.r = r; v.st = st; v.sl = sl; v.be = be; v.tk = tk; v.hr = hr; v.tg = tg;
        v.pc = pc; v.fv = fv; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit st, bit sl, bit be, bit tk, bit hr, int tg);
        rst          = r;
        bus.Start    = st;
        bus.Stall    = sl;
        bus.BranchEn = be;
        bus.Taken    = tk;
        bus.HaltReq  = hr;
        bus.Target   = tg[D-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string nm, int pc, bit fv, bit dn, int cnt);
        chk({nm, " PC"},         int'(bus.PC),         pc);
        chk({nm, " FetchValid"}, int'(bus.FetchValid), int'(fv));
        chk({nm, " Done"},       int'(bus.Done),       int'(dn));
        chk({nm, " InstrCnt"},   int'(bus.InstrCnt),   cnt);
    endtask

    function automatic int branch_dest(int pc, int tg);
        int off;
`ifdef BRANCH_REL_EN
        off = (tg >= MOD / 2) ? tg - MOD : tg;
        return ((pc + off) % MOD + MOD) % MOD;
`else
        off = pc;
        return tg + 0 * off;
`endif
    endfunction

    task automatic model_step(bit r, bit st, bit sl, bit be, bit tk, bit hr, int tg);
        if (r) begin
            m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        end else if (m_st == M_IDLE) begin
            if (st) m_st = M_RUN;
        end else if (m_st == M_HALT) begin
            if (st) begin m_st = M_RUN; m_pc = 0; m_cnt = 0; end
        end else if (hr) begin
            m_st = M_HALT;
        end else if (!sl) begin
            m_pc  = (be && tk) ? branch_dest(m_pc, tg) : (m_pc + 1) % MOD;
            m_cnt = (m_cnt < CNTSAT) ? m_cnt + 1 : CNTSAT;
        end
    endtask

    task automatic go(bit r, bit st, bit sl, bit be, bit tk, bit hr, int tg);
        drive(r, st, sl, be, tk, hr, tg);
        tick();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // Vector table: REQ-034/035/036 paths plus Start-in-RUN and not-taken branches
        tv.push_back(mk(1,0,0,0,0,0,0,     0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,     0,0,0,0));
        tv.push_back(mk(0,1,0,0,0,0,0,     0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,     1,1,0,1));
        tv.push_back(mk(0,0,0,0,0,0,0,     2,1,0,2));
        tv.push_back(mk(0,1,0,0,0,0,0,     3,1,0,3));
        tv.push_back(mk(0,0,0,0,0,0,0,     4,1,0,4));
        tv.push_back(mk(0,0,0,0,0,0,0,     5,1,0,5));
        tv.push_back(mk(1,0,0,0,0,0,0,     0,0,0,0));
        tv.push_back(mk(0,1,0,0,0,0,0,     0,1,0,0));
        for (int k = 1; k <= 4; k++) tv.push_back(mk(0,0,0,0,0,0,0, k,1,0,k));
        tv.push_back(mk(0,0,0,1,1,0,2,     BR_4_2,1,0,5));
        tv.push_back(mk(1,0,0,0,0,0,0,     0,0,0,0));
        tv.push_back(mk(0,1,0,0,0,0,0,     0,1,0,0));
        for (int k = 1; k <= 4; k++) tv.push_back(mk(0,0,0,0,0,0,0, k,1,0,k));
        tv.push_back(mk(0,0,0,1,1,0,12'hFFB, BR_4_FFB,1,0,5));
        tv.push_back(mk(0,0,0,0,0,0,0,     AFTER,1,0,6));
        tv.push_back(mk(0,0,0,1,0,0,100,   (AFTER + 1) % MOD,1,0,7));
        tv.push_back(mk(0,0,0,0,1,0,100,   (AFTER + 2) % MOD,1,0,8));

        for (int i = 0; i < tv.size(); i++) begin
            go(tv[i].r, tv[i].st, tv[i].sl, tv[i].be, tv[i].tk, tv[i].hr, tv[i].tg);
            chk_all($sformatf("tv%0d", i), tv[i].pc, tv[i].fv, tv[i].dn, tv[i].cnt);
        end

        // Stall beats a taken branch; halt beats stall; HALT holds; restart rewinds
        go(1, 0, 0, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) go(0, 0, 0, 0, 0, 0, 0);
        chk_all("at7", 7, 1, 0, 7);
        for (int k = 0; k < 3; k++) begin
            go(0, 0, 1, 1, 1, 0, 100);
            chk_all($sformatf("stall%0d", k), 7, 1, 0, 7);
        end
        go(0, 0, 1, 1, 1, 1, 100);
        chk_all("halt", 7, 0, 1, 7);
        go(0, 0, 0, 1, 1, 0, 100);
        chk_all("halt hold", 7, 0, 1, 7);
        go(0, 1, 0, 0, 0, 0, 0);
        chk_all("restart", 0, 1, 0, 0);
        for (int k = 0; k < 9; k++) go(0, 0, 0, 0, 0, 0, 0);
        chk_all("at9", 9, 1, 0, 9);
        go(1, 1, 1, 1, 1, 0, 100);
        chk_all("reset mid", 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0);
        chk_all("idle hold", 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0);
        chk_all("first start", 0, 1, 0, 0);

        // Counter saturation: 65537 advances leave PC at 65537 mod 4096 = 1
        go(1, 0, 0, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (65537) @(posedge clk);
        #1;
        chk_all("saturate", 1, 1, 0, CNTSAT);

        // Randomised run against the model
        go(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, st, sl, be, tk, hr;
            int tg;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 15);
            sl = ($urandom_range(0, 99) < 20);
            be = ($urandom_range(0, 99) < 30);
            tk = ($urandom_range(0, 1) == 1);
            hr = ($urandom_range(0, 99) < 3);
            tg = int'($urandom_range(0, MOD - 1));
            go(r, st, sl, be, tk, hr, tg);
            model_step(r, st, sl, be, tk, hr, tg);
            chk_all($sformatf("rnd%0d", n), m_pc, m_st == M_RUN, m_st == M_HALT, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter D, default 12, program-counter width in bits.
REQ-002 SHALL have parameter START_ADDR, default 0, PC value loaded on reset and restart.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin or restart execution.
REQ-006 SHALL have port Stall  input  1  hold PC this cycle.
REQ-007 SHALL have port BranchEn  input  1  current instruction is a branch.
REQ-008 SHALL have port Taken  input  1  branch condition true.
REQ-009 SHALL have port Target  input  D  branch target from the jump-target lookup table.
REQ-010 SHALL have port HaltReq  input  1  current instruction is halt.
REQ-011 SHALL have port PC  output  D  instruction-memory address.
REQ-012 SHALL have port FetchValid  output  1  PC addresses a live instruction.
REQ-013 SHALL have port Done  output  1  program finished.
REQ-014 SHALL have port InstrCnt  output  16  count of PC advances since start.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALT; outputs registered, no combinational input-to-output path except none.
REQ-016 IDLE: FetchValid=0, Done=0, PC held; Start=1 -> RUN next cycle, PC unchanged.
REQ-017 RUN: FetchValid=1; next-PC priority per cycle: HaltReq > Stall > (BranchEn&Taken) > PC+1.
REQ-018 RUN, HaltReq=1: PC held, -> HALT, Done=1 from next cycle, InstrCnt not incremented.
REQ-019 RUN, Stall=1 (no HaltReq): PC, InstrCnt held; branch inputs ignored.
REQ-020 RUN, BranchEn&Taken: PC <= branch target per REQ-030/031; InstrCnt+1.
REQ-021 RUN, BranchEn&!Taken or BranchEn=0: PC <= PC+1; InstrCnt+1.
REQ-022 All PC arithmetic modulo 2**D; PC = 2**D-1 advancing by 1 wraps to 0.
REQ-023 InstrCnt saturates at 0xFFFF; no wrap.
REQ-024 HALT: FetchValid=0, Done=1, PC held; Start=1 -> RUN with PC=START_ADDR, InstrCnt=0, Done=0 next cycle.
REQ-025 Start asserted while in RUN SHALL be ignored.

Reset
REQ-026 Reset=1 at a clock edge: state=IDLE, PC=START_ADDR, FetchValid=0, Done=0, InstrCnt=0.
REQ-027 Reset SHALL override all other inputs in the same cycle, in any state, including mid-stall or mid-branch.
REQ-028 First Start honoured on the cycle after Reset deasserts.

Configuration
REQ-029 Macro BRANCH_REL_EN SHALL select branch addressing mode.
REQ-030 BRANCH_REL_EN defined: taken branch PC <= (PC + Target) mod 2**D, Target two's complement (e.g. 0xFFB = -5).
REQ-031 BRANCH_REL_EN undefined: taken branch PC <= Target (absolute).

Structure
REQ-032 Shared package SHALL hold the FSM state enum and the default PC width constant (12).
REQ-033 Next-PC selection SHALL be one combinational sub-module pc_next; the target lookup table stays external, its Target driving this block's Target port.

Verification
REQ-034 Reset, Start, 5 cycles no branch -> PC 0,1,2,3,4,5; FetchValid=1; InstrCnt=5.
REQ-035 Absolute build: PC=4, BranchEn=Taken=1, Target=2 -> PC=2 next cycle; relative build: same stimulus -> PC=6.
REQ-036 Relative build: PC=4, Target=0xFFB -> PC=0xFFF; then no branch -> PC=0x000 (wrap).
REQ-037 Stall=1 and BranchEn=Taken=1 for 3 cycles at PC=7 -> PC stays 7, InstrCnt unchanged; HaltReq with Stall -> HALT, Done=1.
REQ-038 In HALT, Start=1 -> PC=START_ADDR, InstrCnt=0, Done=0, RUN; Reset during RUN at PC=9 -> PC=0, IDLE next cycle.
